// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: mode constants and decode bundle shared by the raster timing generator
package vga_timing_pkg;
  typedef struct packed {
    logic visible;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } decode_t;
  localparam int M640_H_VISIBLE = 640;
  localparam int M640_H_FRONT_PORCH = 16;
  localparam int M640_H_SYNC_PULSE = 96;
  localparam int M640_H_BACK_PORCH = 48;
  localparam int M640_H_WHOLE_LINE = 800;
  localparam int M640_V_VISIBLE = 480;
  localparam int M640_V_FRONT_PORCH = 10;
  localparam int M640_V_SYNC_PULSE = 2;
  localparam int M640_V_BACK_PORCH = 33;
  localparam int M640_V_WHOLE_FRAME = 525;
  localparam bit M640_HSYNC_POL = 1'b0;
  localparam bit M640_VSYNC_POL = 1'b0;
  localparam int M800_H_VISIBLE = 800;
  localparam int M800_H_FRONT_PORCH = 56;
  localparam int M800_H_SYNC_PULSE = 120;
  localparam int M800_H_BACK_PORCH = 64;
  localparam int M800_H_WHOLE_LINE = 1040;
  localparam int M800_V_VISIBLE = 600;
  localparam int M800_V_FRONT_PORCH = 37;
  localparam int M800_V_SYNC_PULSE = 6;
  localparam int M800_V_BACK_PORCH = 23;
  localparam int M800_V_WHOLE_FRAME = 666;
  localparam bit M800_HSYNC_POL = 1'b1;
  localparam bit M800_VSYNC_POL = 1'b1;
  function automatic decode_t idle_decode(input logic hpol, input logic vpol);
    return '{visible: 1'b0, hsync: !hpol, vsync: !vpol, line_start: 1'b0, frame_start: 1'b0};
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enabled shift register for the decode bundle; pass-through at depth 0
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  decode_t rst_val,
  input  decode_t d,
  output decode_t q
);
  localparam int N = DEPTH > 0 ? DEPTH : 1;
  decode_t stage [N];
  // shift one stage per enabled pixel slot; reset flushes every stage to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stage[i] <= rst_val;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end
  assign q = DEPTH == 0 ? d : stage[N-1];
endmodule

// File: rtl/vga_timing.sv
// vga_timing: parametrised raster timing generator; VGA_TIMING_FRAME_COUNT_EN builds the frame counter
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE     = M640_H_VISIBLE,
  parameter int H_FRONT_PORCH = M640_H_FRONT_PORCH,
  parameter int H_SYNC_PULSE  = M640_H_SYNC_PULSE,
  parameter int H_BACK_PORCH  = M640_H_BACK_PORCH,
  parameter int H_WHOLE_LINE  = M640_H_WHOLE_LINE,
  parameter int V_VISIBLE     = M640_V_VISIBLE,
  parameter int V_FRONT_PORCH = M640_V_FRONT_PORCH,
  parameter int V_SYNC_PULSE  = M640_V_SYNC_PULSE,
  parameter int V_BACK_PORCH  = M640_V_BACK_PORCH,
  parameter int V_WHOLE_FRAME = M640_V_WHOLE_FRAME,
  parameter bit HSYNC_POL     = M640_HSYNC_POL,
  parameter bit VSYNC_POL     = M640_VSYNC_POL,
  parameter int COORD_WIDTH   = 10,
  parameter int PIPE_DELAY    = 0,
  parameter int FRAME_WIDTH   = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   pix_en_i,
  output logic [COORD_WIDTH-1:0] column_o,
  output logic [COORD_WIDTH-1:0] row_o,
  output logic                   visible_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   line_start_o,
  output logic                   frame_start_o,
  output logic [FRAME_WIDTH-1:0] frame_o
);
  if (H_WHOLE_LINE != H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH) begin : g_bad_h
    $error("vga_timing: H_WHOLE_LINE does not equal the sum of the horizontal segments");
  end
  if (V_WHOLE_FRAME != V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH) begin : g_bad_v
    $error("vga_timing: V_WHOLE_FRAME does not equal the sum of the vertical segments");
  end
  if ((64'd1 << COORD_WIDTH) < 64'(H_WHOLE_LINE) || (64'd1 << COORD_WIDTH) < 64'(V_WHOLE_FRAME)) begin : g_bad_w
    $error("vga_timing: COORD_WIDTH too small for the raster");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_d
    $error("vga_timing: PIPE_DELAY outside 0..8");
  end
  localparam int CW = COORD_WIDTH + 1;
  localparam logic [COORD_WIDTH-1:0] H_LAST = COORD_WIDTH'(H_WHOLE_LINE - 1);
  localparam logic [COORD_WIDTH-1:0] V_LAST = COORD_WIDTH'(V_WHOLE_FRAME - 1);
  localparam logic [COORD_WIDTH:0] H_VIS_END = CW'(H_VISIBLE);
  localparam logic [COORD_WIDTH:0] H_SYNC_START = CW'(H_VISIBLE + H_FRONT_PORCH);
  localparam logic [COORD_WIDTH:0] H_SYNC_END = CW'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [COORD_WIDTH:0] V_VIS_END = CW'(V_VISIBLE);
  localparam logic [COORD_WIDTH:0] V_SYNC_START = CW'(V_VISIBLE + V_FRONT_PORCH);
  localparam logic [COORD_WIDTH:0] V_SYNC_END = CW'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam decode_t IDLE = idle_decode(HSYNC_POL, VSYNC_POL);
  logic end_line, end_frame;
  logic [COORD_WIDTH:0] col_x, row_x;
  decode_t dec0, dec_q;
  assign end_line = column_o == H_LAST;
  assign end_frame = end_line && row_o == V_LAST;
  assign col_x = {1'b0, column_o};
  assign row_x = {1'b0, row_o};
  // raster position advances one column per enabled slot, wrapping line then frame
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      column_o <= '0;
      row_o <= '0;
    end else if (pix_en_i) begin
      column_o <= end_line ? '0 : column_o + COORD_WIDTH'(1);
      if (end_line) row_o <= end_frame ? '0 : row_o + COORD_WIDTH'(1);
    end
  end
  // stage-0 decode of the current position; vsync spans whole lines of its window
  always_comb begin
    dec0.visible = col_x < H_VIS_END && row_x < V_VIS_END;
    dec0.hsync = (col_x >= H_SYNC_START && col_x < H_SYNC_END) ? HSYNC_POL : !HSYNC_POL;
    dec0.vsync = (row_x >= V_SYNC_START && row_x < V_SYNC_END) ? VSYNC_POL : !VSYNC_POL;
    dec0.line_start = column_o == '0;
    dec0.frame_start = column_o == '0 && row_o == '0;
  end
  vga_delay_line #(.DEPTH(PIPE_DELAY)) u_delay (
    .clk(clk_i),
    .rst(reset_i),
    .en(pix_en_i),
    .rst_val(IDLE),
    .d(dec0),
    .q(dec_q)
  );
  assign visible_o = dec_q.visible;
  assign hsync_o = dec_q.hsync;
  assign vsync_o = dec_q.vsync;
  assign line_start_o = dec_q.line_start;
  assign frame_start_o = dec_q.frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  // count completed frames on the slot that wraps the raster back to the origin
  always_ff @(posedge clk_i) begin
    if (reset_i) frame_o <= '0;
    else if (pix_en_i && end_frame) frame_o <= frame_o + FRAME_WIDTH'(1);
  end
`else
  assign frame_o = '0;
`endif
endmodule
